instr_sequencer: RTL
====================

// Module: instr_sequencer
// PURPOSE
//  Multi-cycle control FSM that sequences each instruction through FETCH/DECODE/EXEC/(MEM)/WB.
//  Drives the PC register's load enable and branch select; replaces the fixed 6-cycle PC cadence
//  with a variable 4-cycle (ALU) / 5+N-cycle (memory) schedule.
//  Sits between the decoder/ALU/data-memory handshake and the PC, IR and register file.
// PARAMETERS
//  D        12   PC / branch-target width
//  CNT_W    16   retired-instruction counter width
//  TIMEOUT  15   max cycles MEM waits for mem_ready before ERR (1..2^4-1)
// PORTS
//  clk            in   1      clock; all state on rising edge
//  reset          in   1      asynchronous, active-low (0 = reset asserted)
//  start          in   1      begin execution at start_addr; honoured only in IDLE/HALT/ERR
//  start_addr     in   D      first PC value, sampled with start
//  abort          in   1      synchronous; forces IDLE next cycle from any state
//  instr_is_mem   in   1      decoder flag, sampled in DECODE
//  instr_is_halt  in   1      decoder flag, sampled in DECODE
//  branch_taken   in   1      ALU flag, sampled in EXEC
//  branch_target  in   D      ALU target, sampled in EXEC
//  mem_ready      in   1      data-memory completion, sampled in MEM
//  pc_en          out  1      PC register loads pc_target (branch) or PC+1 this edge
//  pc_branch      out  1      1: PC loads pc_target; 0: PC increments
//  pc_target      out  D      absolute load value for PC
//  ir_load        out  1      instruction register capture strobe
//  reg_we         out  1      register-file write strobe
//  mem_req        out  1      data-memory request, held until mem_ready
//  phase          out  4      current state encoding (state_t)
//  running        out  1      1 in any state other than IDLE/HALT/ERR
//  halted         out  1      1 in HALT
//  fault          out  1      1 in ERR
//  instr_count    out  CNT_W  retired instructions since last start; wraps to 0
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; every output 0; internal flags/target regs 0.
//  Outputs are Moore-decoded from registered state and flag regs; no input-to-output comb paths.
//  States / transitions (one cycle each unless noted):
//   IDLE   : start -> LOAD (start_addr captured into target reg); else stay.
//   LOAD   : pc_en=1, pc_branch=1, pc_target=captured start_addr -> FETCH.
//   FETCH  : ir_load=1 -> DECODE.
//   DECODE : latch is_mem, is_halt. is_halt -> HALT; else -> EXEC.
//   EXEC   : latch branch_taken, branch_target. is_mem -> MEM; else -> WB.
//   MEM    : mem_req=1 every cycle. mem_ready=1 -> WB. Wait counter clears on entry, +1 per
//            cycle with mem_ready=0; reaching TIMEOUT with mem_ready=0 -> ERR.
//   WB     : reg_we=1, pc_en=1, pc_branch=latched taken, pc_target=latched target
//            (0 when not taken); instr_count+1 -> FETCH.
//   HALT   : halted=1; start -> LOAD (instr_count cleared).
//   ERR    : fault=1 (sticky); start -> LOAD (fault and instr_count cleared).
//  Latency: ALU instr 4 cycles FETCH..WB; memory instr 5 + (cycles mem_ready low).
//  Priority: reset > abort > start > normal transition. abort in IDLE: no effect.
//  start while running: ignored. start and abort same cycle: abort wins -> IDLE.
//  mem_ready outside MEM: ignored. mem_ready=1 on the TIMEOUT cycle: WB (not ERR).
//  instr_count at 2^CNT_W-1 wraps to 0 on next retire. Halt instr is not counted.
//  pc_target width D; start_addr/branch_target pass through unmodified, no wrap logic here.
//  Reset mid-MEM: mem_req drops immediately (async); no retire counted.
// STRUCTURE
//  Package seq_pkg: typedef enum logic[3:0] state_t {IDLE=0,LOAD=1,FETCH=2,DECODE=3,EXEC=4,
//   MEM=5,WB=6,HALT=7,ERR=8}; localparam PHASE_W=4. Imported by decoder/debug monitors.
//  Sub-module mem_wait_timer (clear, en, TIMEOUT param -> expired) holds the MEM wait counter.
// TESTING
//  1. reset=0 mid-EXEC -> all outputs 0 and phase=0 same cycle; release, no start -> IDLE held.
//  2. start, start_addr=0x010, 3 ALU instrs no branch -> pc_en in LOAD then every 4th cycle,
//     pc_branch=0 in WB, instr_count=3.
//  3. EXEC branch_taken=1, branch_target=0xA5C -> WB: pc_en=1, pc_branch=1, pc_target=0xA5C.
//  4. mem instr, mem_ready low 3 cycles then high -> mem_req high 4 cycles, WB next, count+1;
//     mem_ready never high -> ERR after 15 MEM cycles, fault=1, start recovers.
//  5. instr_is_halt in DECODE -> HALT, halted=1, count unchanged; start with abort same cycle
//     -> IDLE.
//  6. preload instr_count=0xFFFF (force) + one retire -> 0x0000.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer and anything that decodes
// its phase output (decoder, debug monitors).
//   PHASE_W   : width of the phase/state encoding
//   state_t   : sequencer state encoding, exported on the phase output
//   is_active : 1 for states in which an instruction is in flight
package seq_pkg;

  localparam int PHASE_W = 4;

  typedef enum logic [PHASE_W-1:0] {
    IDLE   = 4'd0,
    LOAD   = 4'd1,
    FETCH  = 4'd2,
    DECODE = 4'd3,
    EXEC   = 4'd4,
    MEM    = 4'd5,
    WB     = 4'd6,
    HALT   = 4'd7,
    ERR    = 4'd8
  } state_t;

  // IDLE, HALT and ERR are the parked states; everything else is executing.
  function automatic logic is_active(state_t s);
    return !((s == IDLE) || (s == HALT) || (s == ERR));
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Bundle of every sequencer signal other than clock and reset.
//   master : the surrounding datapath/controller side (drives control and
//            decoder/ALU/memory flags, observes PC/IR/RF strobes and status)
//   slave  : the sequencer itself
// Handshake: mem_req is held high for every cycle spent waiting on data
// memory; the access completes in the cycle mem_ready is sampled high while
// mem_req is high. mem_ready at any other time carries no meaning.
interface instr_sequencer_if #(
  parameter int D     = 12,
  parameter int CNT_W = 16
);
  // control and flags into the sequencer
  logic                        start;
  logic [D-1:0]                start_addr;
  logic                        abort;
  logic                        instr_is_mem;
  logic                        instr_is_halt;
  logic                        branch_taken;
  logic [D-1:0]                branch_target;
  logic                        mem_ready;
  // strobes and status out of the sequencer
  logic                        pc_en;
  logic                        pc_branch;
  logic [D-1:0]                pc_target;
  logic                        ir_load;
  logic                        reg_we;
  logic                        mem_req;
  logic [seq_pkg::PHASE_W-1:0] phase;
  logic                        running;
  logic                        halted;
  logic                        fault;
  logic [CNT_W-1:0]            instr_count;

  modport master (
    output start, start_addr, abort, instr_is_mem, instr_is_halt,
           branch_taken, branch_target, mem_ready,
    input  pc_en, pc_branch, pc_target, ir_load, reg_we, mem_req,
           phase, running, halted, fault, instr_count
  );

  modport slave (
    input  start, start_addr, abort, instr_is_mem, instr_is_halt,
           branch_taken, branch_target, mem_ready,
    output pc_en, pc_branch, pc_target, ir_load, reg_we, mem_req,
           phase, running, halted, fault, instr_count
  );

endinterface

// File: rtl/instr_sequencer_mem_wait_timer.sv
// Counts cycles the sequencer spends in MEM without mem_ready.
//   clk, reset : clock, asynchronous active-low reset
//   clear      : hold the count at zero (asserted whenever not in MEM)
//   en         : this cycle is a waiting cycle (in MEM, mem_ready low)
//   expired    : this waiting cycle is the TIMEOUT-th one
module mem_wait_timer #(
  parameter int TIMEOUT = 15,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // cnt_q holds the number of earlier waiting cycles, so the current one is
  // number cnt_q+1; it is the last allowed when that reaches TIMEOUT.
  assign expired = en && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control FSM: steps each instruction through
// FETCH/DECODE/EXEC/(MEM)/WB and drives the PC load/branch controls, the IR
// capture strobe, the register-file write strobe and the data-memory request.
//   clk   : clock, all state on the rising edge
//   reset : asynchronous, active-low
//   bus   : instr_sequencer_if.slave (control, decoder/ALU/memory flags,
//           PC/IR/RF strobes, phase/running/halted/fault status, instr_count)
// All outputs decode from registered state only.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int D       = 12,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  instr_sequencer_if.slave    bus
);

  state_t           state_q, state_d;
  logic [D-1:0]     target_q;   // start address in LOAD, branch target in WB
  logic             taken_q;
  logic             is_mem_q;
  logic [CNT_W-1:0] count_q;
  logic             timer_expired;
  logic             accept_start;

  // start only counts while parked, and abort overrides it.
  assign accept_start = bus.start && !bus.abort && !is_active(state_q);

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q != MEM),
    .en      ((state_q == MEM) && !bus.mem_ready),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, HALT, ERR: if (bus.start) state_d = LOAD;
        LOAD:            state_d = FETCH;
        FETCH:           state_d = DECODE;
        DECODE:          state_d = bus.instr_is_halt ? HALT : EXEC;
        EXEC:            state_d = is_mem_q ? MEM : WB;
        // completion beats timeout when both land in the same cycle
        MEM: begin
          if (bus.mem_ready)  state_d = WB;
          else if (timer_expired) state_d = ERR;
        end
        WB:              state_d = FETCH;
        default:         state_d = IDLE;
      endcase
    end
  end

  // Per-instruction flags, shared target register and retire counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      target_q <= '0;
      taken_q  <= 1'b0;
      is_mem_q <= 1'b0;
      count_q  <= '0;
    end else if (!bus.abort) begin
      if (accept_start) begin
        target_q <= bus.start_addr;
        count_q  <= '0;
      end
      if (state_q == DECODE) begin
        is_mem_q <= bus.instr_is_mem;
      end
      if (state_q == EXEC) begin
        taken_q  <= bus.branch_taken;
        target_q <= bus.branch_taken ? bus.branch_target : '0;
      end
      if (state_q == WB) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  // LOAD always performs an absolute load; WB loads only on a taken branch.
  assign bus.pc_en       = (state_q == LOAD) || (state_q == WB);
  assign bus.pc_branch   = (state_q == LOAD) || ((state_q == WB) && taken_q);
  assign bus.pc_target   = bus.pc_en ? target_q : '0;
  assign bus.ir_load     = (state_q == FETCH);
  assign bus.reg_we      = (state_q == WB);
  assign bus.mem_req     = (state_q == MEM);
  assign bus.phase       = state_q;
  assign bus.running     = is_active(state_q);
  assign bus.halted      = (state_q == HALT);
  assign bus.fault       = (state_q == ERR);
  assign bus.instr_count = count_q;

endmodule
